// File: rtl/fdtd_rd_seq.sv
// fdtd_rd_seq: strided word-read sequencer feeding the FDTD datapath.
// Issues one word read at a time to an AXI word-read master, buffers the
// returned words in a small FIFO and streams them out with a last marker.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_i; the command is sampled on acceptance
// RUN   | issuing reads while words remain and the FIFO has room
// DDRAIN| all reads granted; waiting for the FIFO to empty
// DONE  | one-cycle completion pulse, then back to IDLE
module fdtd_rd_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-3:0] base_word_addr_i,
  input  logic [CNT_WIDTH-1:0]  stride_i,
  input  logic [CNT_WIDTH-1:0]  count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rd_req_o,
  output logic [ADDR_WIDTH-3:0] rd_word_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  rd_gnt_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i
);

  localparam int AW = ADDR_WIDTH - 2;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  logic                 pending;
  logic [AW-1:0]        addr;
  logic [CNT_WIDTH-1:0] stride_r;
  logic [CNT_WIDTH-1:0] remaining;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic [LW-1:0]         level_nxt;

  logic grant;
  logic push;
  logic pop;
  logic last_word;
  logic can_issue;

  // A grant only counts while our own request is outstanding; stray grants are dropped.
  assign grant     = pending & rd_gnt_i;
  assign push      = grant;
  assign pop       = (level != '0) & out_ready_i;
  assign last_word = (remaining == CNT_WIDTH'(1));
  // Room is checked at issue time, so the slot is guaranteed free at grant.
  assign can_issue = (state == RUN) && !pending && (remaining != '0) &&
                     (level < LW'(FIFO_DEPTH));

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + LW'(1);
    else if (!push && pop)
      level_nxt = level - LW'(1);
  end

  // Sequencer FSM with request flag, address walker and word counter.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= IDLE;
      pending   <= 1'b0;
      addr      <= '0;
      stride_r  <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            addr      <= base_word_addr_i;
            stride_r  <= stride_i;
            remaining <= count_i;
            if (count_i != '0) begin
              state   <= RUN;
              pending <= 1'b1;
            end else begin
              state   <= DONE;
            end
          end
        end
        RUN: begin
          if (grant) begin
            pending   <= 1'b0;
            addr      <= addr + AW'(stride_r);
            remaining <= remaining - CNT_WIDTH'(1);
            if (last_word)
              state <= DRAIN;
          end else if (can_issue) begin
            pending <= 1'b1;
          end
        end
        DRAIN: begin
          if (level_nxt == '0)
            state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and level.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      level <= level_nxt;
    end
  end

  // FIFO storage; contents are don't-care until the level covers them.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_data[wr_ptr] <= rd_data_i;
      mem_last[wr_ptr] <= last_word;
    end
  end

  assign rd_req_o       = pending & ~rd_gnt_i;
  assign rd_word_addr_o = addr;
  assign out_valid_o    = (level != '0);
  assign out_data_o     = out_valid_o ? mem_data[rd_ptr] : '0;
  assign out_last_o     = out_valid_o & mem_last[rd_ptr];
  assign busy_o         = (state == RUN) || (state == DRAIN);
  assign done_o         = (state == DONE);

endmodule
